// File: rtl/mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_if                                                     |
// | Request/response bundle between a pipeline memory stage and          |
// | mem_responder.                                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output busy_o, ack_o, rdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  busy_o, ack_o, rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Fixed-latency word memory: accepts one load/store, acks LATENCY      |
// | cycles later with a single-cycle pulse.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    mem_responder_if.slave bus
);
    localparam int         C_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] C_LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_ACK  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [C_AW-1:0] addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem_q [DEPTH];

    logic [C_AW-1:0] w_rd_idx;
    logic            w_rd_we;
    logic            w_unused_addr;

    // With LATENCY=1 the load reads straight from the accepting inputs.
    assign w_rd_idx = (state_q == C_IDLE) ? bus.addr_i[C_AW+1:2] : addr_q;
    assign w_rd_we  = (state_q == C_IDLE) ? bus.we_i : we_q;
    assign w_unused_addr = ^{bus.addr_i[31:C_AW+2], bus.addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            C_IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i[C_AW+1:2];
                    wdata_d = bus.wdata_i;
                    cnt_d   = C_LAT_M1;
                    state_d = (LATENCY == 1) ? C_ACK : C_WAIT;
                end
            end
            C_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = C_ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase

        if (state_d == C_ACK && !w_rd_we) begin
            rdata_d = mem_q[w_rd_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= C_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; an aborted store never reaches ACK so never commits.
    always_ff @(posedge clk_i) begin
        if (state_q == C_ACK && we_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.busy_o  = (state_q != C_IDLE);
    assign bus.ack_o   = (state_q == C_ACK);
    assign bus.rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder                                                     |
// | Randomized bench for mem_responder with a word-array reference.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_responder;
    localparam int LAT  = 4;
    localparam int DEP  = 256;
    localparam int DEP1 = 16;
    localparam logic [LAT:0] EXP_BUSY = {1'b0, {LAT{1'b1}}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    mem_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus0)
    );
    mem_responder #(.LATENCY(1), .DEPTH(DEP1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus1)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] model0 [DEP];
    logic [31:0] model1 [DEP1];
    logic [31:0] last_rd0 = 32'h0;
    logic [31:0] last_rd1 = 32'h0;

    function automatic int widx0(input logic [31:0] a);
        return int'((a >> 2) % DEP);
    endfunction

    function automatic int widx1(input logic [31:0] a);
        return int'((a >> 2) % DEP1);
    endfunction

    // Issues one request on bus0 and observes the LAT+1 cycles that follow.
    task automatic do_txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int ack_at, output int n_ack, output logic [31:0] rd,
                           output logic [LAT:0] busy_seen);
        bus0.req_i = 1'b1; bus0.we_i = we; bus0.addr_i = addr; bus0.wdata_i = wdata;
        ack_at = -1; n_ack = 0; rd = 32'h0; busy_seen = '0;
        @(posedge clk); #1;
        bus0.req_i = 1'b0; bus0.we_i = 1'($urandom_range(1));
        bus0.addr_i = $urandom; bus0.wdata_i = $urandom;
        for (int k = 0; k <= LAT; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            busy_seen[k] = bus0.busy_o;
            if (bus0.ack_o) begin n_ack++; ack_at = k; rd = bus0.rdata_o; end
        end
    endtask

    task automatic test_reset;
        bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = 32'h0; bus0.wdata_i = 32'h0;
        bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = 32'h0; bus1.wdata_i = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus0.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus0.busy_o); end
        tests++; if (bus0.ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", bus0.ack_o); end
        tests++; if (bus0.rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus0.rdata_o); end
        tests++; if ({bus1.busy_o, bus1.ack_o, bus1.rdata_o} !== 34'h0) begin
            fails++; $display("FAIL reset_dut1: busy=%b ack=%b rdata=%h want all 0", bus1.busy_o, bus1.ack_o, bus1.rdata_o);
        end
        rst_n = 1'b1;
        last_rd0 = 32'h0; last_rd1 = 32'h0;
    endtask

    task automatic test_fill;
        int at, na; logic [31:0] rd, d, a; logic [LAT:0] bs;
        for (int i = 0; i < DEP; i++) begin
            d = $urandom;
            a = ($urandom & 32'hFFFF_FC00) | 32'(i << 2) | ($urandom & 32'h3);
            do_txn0(1'b1, a, d, at, na, rd, bs);
            tests++;
            if (at != LAT-1 || na != 1 || bs !== EXP_BUSY || rd !== last_rd0) begin
                fails++;
                $display("FAIL fill[%0d]: ack_at=%0d n_ack=%0d busy=%b rdata=%h, want ack_at=%0d n_ack=1 busy=%b rdata=%h",
                         i, at, na, bs, rd, LAT-1, EXP_BUSY, last_rd0);
            end
            model0[widx0(a)] = d;
        end
    endtask

    task automatic test_store_load;
        int at, na; logic [31:0] rd; logic [LAT:0] bs;
        logic [31:0] addrs [3] = '{32'h10, 32'h10, 32'h13};
        logic        wes   [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            do_txn0(wes[i], addrs[i], 32'hDEAD_BEEF, at, na, rd, bs);
            if (wes[i]) begin
                exp = last_rd0;
                model0[widx0(addrs[i])] = 32'hDEAD_BEEF;
            end else begin
                exp = model0[widx0(addrs[i])];
                last_rd0 = exp;
            end
            tests++;
            if (at != LAT-1 || na != 1 || bs !== EXP_BUSY || rd !== exp) begin
                fails++;
                $display("FAIL store_load[%0d] addr=%h: ack_at=%0d n_ack=%0d busy=%b rdata=%h, want ack_at=%0d n_ack=1 busy=%b rdata=%h",
                         i, addrs[i], at, na, bs, rd, LAT-1, EXP_BUSY, exp);
            end
        end
        tests++;
        if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_0x13: got %h want deadbeef", rd); end
    endtask

    task automatic test_wrap;
        int at, na; logic [31:0] rd; logic [LAT:0] bs;
        do_txn0(1'b1, 32'h400, 32'h1234_5678, at, na, rd, bs);
        model0[widx0(32'h400)] = 32'h1234_5678;
        do_txn0(1'b0, 32'h000, 32'h0, at, na, rd, bs);
        last_rd0 = model0[widx0(32'h000)];
        tests++;
        if (at != LAT-1 || rd !== last_rd0) begin
            fails++; $display("FAIL wrap: ack_at=%0d rdata=%h, want ack_at=%0d rdata=%h", at, rd, LAT-1, last_rd0);
        end
    endtask

    task automatic test_random;
        int at, na; logic [31:0] rd, a, d, exp; logic [LAT:0] bs; logic we;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(1)); a = $urandom; d = $urandom;
            do_txn0(we, a, d, at, na, rd, bs);
            if (we) begin
                exp = last_rd0; model0[widx0(a)] = d;
            end else begin
                exp = model0[widx0(a)]; last_rd0 = exp;
            end
            tests++;
            if (at != LAT-1 || na != 1 || bs !== EXP_BUSY || rd !== exp) begin
                fails++;
                $display("FAIL random[%0d] we=%b addr=%h: ack_at=%0d n_ack=%0d busy=%b rdata=%h, want ack_at=%0d n_ack=1 busy=%b rdata=%h",
                         i, we, a, at, na, bs, rd, LAT-1, EXP_BUSY, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int NREQ = 3 * (LAT + 1);
        localparam int NC   = NREQ + LAT + 1;
        logic        exp_ack [NC + LAT];
        logic [31:0] exp_dat [NC + LAT];
        logic [31:0] a;
        int next_ok = 0, n_ack = 0, n_exp = 0;
        for (int i = 0; i < NC + LAT; i++) begin exp_ack[i] = 1'b0; exp_dat[i] = 32'h0; end
        for (int c = 0; c < NC; c++) begin
            a = $urandom;
            bus0.req_i = (c < NREQ); bus0.we_i = 1'b0; bus0.addr_i = a; bus0.wdata_i = $urandom;
            if (c < NREQ && c >= next_ok) begin
                exp_ack[c+LAT-1] = 1'b1;
                exp_dat[c+LAT-1] = model0[widx0(a)];
                next_ok = c + LAT + 1;
                n_exp++;
            end
            @(posedge clk); #1;
            if (bus0.ack_o) n_ack++;
            if (exp_ack[c]) last_rd0 = exp_dat[c];
            tests++;
            if (bus0.ack_o !== exp_ack[c] || bus0.rdata_o !== last_rd0) begin
                fails++;
                $display("FAIL b2b cycle %0d: ack=%b rdata=%h, want ack=%b rdata=%h",
                         c, bus0.ack_o, bus0.rdata_o, exp_ack[c], last_rd0);
            end
        end
        bus0.req_i = 1'b0;
        tests++;
        if (n_ack != n_exp) begin fails++; $display("FAIL b2b_count: got %0d acks want %0d", n_ack, n_exp); end
    endtask

    task automatic test_reset_abort;
        int at, na; logic [31:0] rd; logic [LAT:0] bs; int bad = 0;
        do_txn0(1'b1, 32'h20, 32'h1111_1111, at, na, rd, bs);
        model0[widx0(32'h20)] = 32'h1111_1111;
        do_txn0(1'b0, 32'h24, 32'h0, at, na, rd, bs);
        last_rd0 = model0[widx0(32'h24)];
        bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 32'h20; bus0.wdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus0.req_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus0.busy_o, bus0.ack_o, bus0.rdata_o} !== 34'h0) begin
            fails++; $display("FAIL abort_async: busy=%b ack=%b rdata=%h want all 0", bus0.busy_o, bus0.ack_o, bus0.rdata_o);
        end
        repeat (LAT + 1) begin
            @(posedge clk); #1;
            if (bus0.ack_o !== 1'b0 || bus0.busy_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL abort_hold: %0d cycles with ack/busy set, want 0", bad); end
        rst_n = 1'b1;
        last_rd0 = 32'h0; last_rd1 = 32'h0;
        do_txn0(1'b0, 32'h20, 32'h0, at, na, rd, bs);
        last_rd0 = model0[widx0(32'h20)];
        tests++;
        if (at != LAT-1 || na != 1 || rd !== last_rd0) begin
            fails++; $display("FAIL abort_readback: ack_at=%0d n_ack=%0d rdata=%h, want ack_at=%0d n_ack=1 rdata=%h",
                              at, na, rd, LAT-1, last_rd0);
        end
    endtask

    task automatic test_latency1;
        logic we; logic [31:0] a, d, exp;
        for (int i = 0; i < DEP1 + 22; i++) begin
            if (i < DEP1) begin
                we = 1'b1; a = 32'(i << 2); d = $urandom;
            end else if (i == DEP1 + 20) begin
                we = 1'b1; a = 32'h44; d = 32'hA5A5_0001;
            end else if (i == DEP1 + 21) begin
                we = 1'b0; a = 32'h04; d = $urandom;
            end else begin
                we = 1'($urandom_range(1)); a = $urandom; d = $urandom;
            end
            if (we) begin
                exp = last_rd1; model1[widx1(a)] = d;
            end else begin
                exp = model1[widx1(a)]; last_rd1 = exp;
            end
            bus1.req_i = 1'b1; bus1.we_i = we; bus1.addr_i = a; bus1.wdata_i = d;
            @(posedge clk); #1;
            bus1.req_i = 1'b0; bus1.addr_i = $urandom; bus1.wdata_i = $urandom;
            tests++;
            if (bus1.ack_o !== 1'b1 || bus1.busy_o !== 1'b1 || bus1.rdata_o !== exp) begin
                fails++; $display("FAIL lat1_ack[%0d] we=%b addr=%h: ack=%b busy=%b rdata=%h, want ack=1 busy=1 rdata=%h",
                                  i, we, a, bus1.ack_o, bus1.busy_o, bus1.rdata_o, exp);
            end
            @(posedge clk); #1;
            tests++;
            if (bus1.ack_o !== 1'b0 || bus1.busy_o !== 1'b0 || bus1.rdata_o !== exp) begin
                fails++; $display("FAIL lat1_idle[%0d]: ack=%b busy=%b rdata=%h, want ack=0 busy=0 rdata=%h",
                                  i, bus1.ack_o, bus1.busy_o, bus1.rdata_o, exp);
            end
        end
        tests++;
        if (last_rd1 !== 32'hA5A5_0001) begin fails++; $display("FAIL lat1_wrap: got %h want a5a50001", last_rd1); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
